// File: rtl/lcb_pkg.sv
// Shared constants and state encoding for the LCB write-side buffer arbiter.
// A bank holds 2^AW words; each of the four channels owns one quarter of it.
package lcb_pkg;

   localparam int DW     = 12;
   localparam int AW     = 10;
   localparam int NCH    = 4;
   localparam int CW     = AW - 1;            // per-channel count width, holds 0..REGION
   localparam int REGION = 1 << (AW - 2);
   localparam logic [DW-1:0] FILL = 12'hFFF;

   typedef logic [0:0] lcbState;
   localparam lcbState CLEAR = 1'b0;
   localparam lcbState RUN   = 1'b1;

endpackage

// File: rtl/lcb_buf_arbiter_rr_arb4.sv
// Four-request round-robin arbiter: combinational grant of the first request
// at or after the pointer, pointer moves past the winner on every grant.
module rr_arb4 (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] iReq,
   output logic [3:0] oGnt,
   output logic [1:0] oGntIdx,
   output logic       oGntValid
);

   logic [1:0] ptr;
   logic [1:0] idx;

   // Scan from the farthest offset down so the nearest request wins last.
   always_comb begin
      oGntIdx   = ptr;
      oGntValid = 1'b0;
      idx       = '0;
      for (int k = 3; k >= 0; k--) begin
         idx = ptr + 2'(k);
         if (iReq[idx]) begin
            oGntIdx   = idx;
            oGntValid = 1'b1;
         end
      end
      oGnt = oGntValid ? (4'b0001 << oGntIdx) : 4'b0000;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr <= '0;
      end else if (oGntValid) begin
         ptr <= oGntIdx + 2'd1;
      end
   end

endmodule

// File: rtl/lcb_buf_arbiter.sv
// Collects words from four LCB channels and schedules them onto the single
// ping-pong memory write port, pre-filling the write bank after each toggle.
module lcb_buf_arbiter
   import lcb_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                iSwitch,
   input  logic [NCH-1:0]      iValid,
   input  logic [NCH*DW-1:0]   iData,
   output logic [NCH-1:0]      oReady,
   output logic                oWrEn,
   output logic                oWrBank,
   output logic [AW-1:0]       oWrAddr,
   output logic [DW-1:0]       oWrData,
   output logic [NCH*CW-1:0]   oFillCnt,
   output logic [NCH-1:0]      oOvf,
   input  logic                iClrOvf
);

   logic            swD;
   logic            toggle;
   lcbState         state;
   lcbState         stateNext;
   logic [AW-1:0]   clrAddr;
   logic [NCH-1:0]  full;
   logic [NCH-1:0]  fullNext;
   logic [NCH-1:0]  gnt;
   logic [NCH-1:0]  cntSat;
   logic [1:0]      gntIdx;
   logic            gntValid;
   logic [DW-1:0]   holdData [NCH];
   logic [CW-1:0]   cnt [NCH];

   assign toggle    = iSwitch ^ swD;
   assign stateNext = toggle ? CLEAR
                    : ((state == CLEAR) && (clrAddr == '1)) ? RUN : state;

   rr_arb4 uArb (
      .clk       (clk),
      .reset     (reset),
      .iReq      (full & {NCH{state == RUN}}),
      .oGnt      (gnt),
      .oGntIdx   (gntIdx),
      .oGntValid (gntValid)
   );

   for (genvar gi = 0; gi < NCH; gi++) begin : gCh
      logic          accept;
      logic          fullR;
      logic          ovfR;
      logic [DW-1:0] holdR;
      logic [CW-1:0] cntR;

      assign accept       = iValid[gi] & oReady[gi];
      assign fullNext[gi] = accept | (fullR & ~gnt[gi]);
      assign cntSat[gi]   = (cntR == CW'(REGION));
      assign full[gi]     = fullR;
      assign holdData[gi] = holdR;
      assign cnt[gi]      = cntR;
      assign oOvf[gi]     = ovfR;

      // A grant coinciding with a toggle still empties the hold register,
      // but the word is neither written nor counted.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            fullR <= 1'b0;
            holdR <= '0;
            cntR  <= '0;
            ovfR  <= 1'b0;
         end else begin
            fullR <= fullNext[gi];
            if (accept) holdR <= iData[gi*DW +: DW];
            if (toggle)
               cntR <= '0;
            else if (gnt[gi] && !cntSat[gi])
               cntR <= cntR + 1'b1;
            ovfR <= (ovfR & ~iClrOvf) | (gnt[gi] & ~toggle & cntSat[gi]);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         swD      <= 1'b0;
         state    <= CLEAR;
         clrAddr  <= '0;
         oReady   <= '0;
         oWrEn    <= 1'b0;
         oWrBank  <= 1'b0;
         oWrAddr  <= '0;
         oWrData  <= '0;
         oFillCnt <= '0;
      end else begin
         swD    <= iSwitch;
         state  <= stateNext;
         oReady <= {NCH{stateNext == RUN}} & ~fullNext;
         oWrEn  <= 1'b0;
         if (toggle) begin
            oWrBank <= ~iSwitch;
            clrAddr <= '0;
            for (int n = 0; n < NCH; n++) oFillCnt[n*CW +: CW] <= cnt[n];
         end else if (state == CLEAR) begin
            oWrEn   <= 1'b1;
            oWrAddr <= clrAddr;
            oWrData <= FILL;
            clrAddr <= clrAddr + 1'b1;
         end else if (gntValid && !cntSat[gntIdx]) begin
            oWrEn   <= 1'b1;
            oWrAddr <= {gntIdx, cnt[gntIdx][CW-2:0]};
            oWrData <= holdData[gntIdx];
         end
      end
   end

endmodule

// File: tb/tb_lcb_buf_arbiter.sv
// Directed bench for lcb_buf_arbiter: expected memory writes are queued as
// stimulus is issued and matched in order against every observed write.
module tb_lcb_buf_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        iSwitch = 1'b0;
   logic [3:0]  iValid = '0;
   logic [47:0] iData = '0;
   logic        iClrOvf = 1'b0;
   logic [3:0]  oReady;
   logic        oWrEn;
   logic        oWrBank;
   logic [9:0]  oWrAddr;
   logic [11:0] oWrData;
   logic [35:0] oFillCnt;
   logic [3:0]  oOvf;

   typedef struct packed {
      logic        clr;
      logic        bank;
      logic [9:0]  addr;
      logic [11:0] data;
   } wr_t;

   wr_t         expQ [$];
   logic [11:0] srcQ [4][$];
   logic [3:0]  hs;
   int          checks = 0;
   int          errors = 0;

   lcb_buf_arbiter dut (
      .clk      (clk),
      .reset    (reset),
      .iSwitch  (iSwitch),
      .iValid   (iValid),
      .iData    (iData),
      .oReady   (oReady),
      .oWrEn    (oWrEn),
      .oWrBank  (oWrBank),
      .oWrAddr  (oWrAddr),
      .oWrData  (oWrData),
      .oFillCnt (oFillCnt),
      .oOvf     (oOvf),
      .iClrOvf  (iClrOvf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic wr_t mkWr(input logic bank, input logic [9:0] addr,
                                input logic [11:0] data, input logic clr);
      wr_t w;
      w.clr  = clr;
      w.bank = bank;
      w.addr = addr;
      w.data = data;
      return w;
   endfunction

   task automatic pushClear(input logic bank, input int n);
      for (int i = 0; i < n; i++) expQ.push_back(mkWr(bank, 10'(i), 12'hFFF, 1'b1));
   endtask

   task automatic waitDrain(input string tag, input int budget);
      int n = 0;
      while (expQ.size() > 0 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk(tag, 48'(expQ.size()), 48'd0);
   endtask

   // Monitor: each write is popped against the queue head.
   always @(negedge clk) begin
      if (reset && oWrEn) begin
         wr_t e;
         checks++;
         assert (expQ.size() != 0)
         else begin
            errors++;
            $error("FAIL unexpected_write observed bank %0d addr %0d data %h expected none",
                   oWrBank, oWrAddr, oWrData);
         end
         if (expQ.size() != 0) begin
            e = expQ.pop_front();
            chk("write", {25'd0, oWrBank, oWrAddr, oWrData}, {25'd0, e.bank, e.addr, e.data});
            if (e.clr && e.addr != 10'd1023) chk("clear_ready", 48'(oReady), 48'd0);
         end
      end
   end

   // Channel sources: present queue heads, retire a word after each handshake.
   always begin
      @(negedge clk);
      hs = iValid & oReady;
      @(posedge clk);
      #1;
      for (int n = 0; n < 4; n++) begin
         if (hs[n]) void'(srcQ[n].pop_front());
         if (srcQ[n].size() > 0) begin
            iValid[n] = 1'b1;
            iData[n*12 +: 12] = srcQ[n][0];
         end else begin
            iValid[n] = 1'b0;
         end
      end
   end

   initial begin
      logic [11:0] w;
      int n;

      repeat (3) @(negedge clk);
      chk("reset_wren", 48'(oWrEn), 48'd0);
      chk("reset_ready", 48'(oReady), 48'd0);
      chk("reset_fill", 48'(oFillCnt), 48'd0);
      chk("reset_ovf", 48'(oOvf), 48'd0);
      chk("reset_bank", 48'(oWrBank), 48'd0);

      pushClear(1'b0, 1024);
      reset = 1'b1;
      waitDrain("init_clear", 1100);
      repeat (3) @(negedge clk);
      chk("ready_after_clear", 48'(oReady), 48'hF);
      chk("idle_wren", 48'(oWrEn), 48'd0);

      // All four channels streaming: one write per cycle in channel rotation.
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         for (int ch = 0; ch < 4; ch++) begin
            w = 12'(ch * 256 + i) ^ 12'hA5A;
            srcQ[ch].push_back(w);
            expQ.push_back(mkWr(1'b0, 10'(ch * 256 + i), w, 1'b0));
         end
      end
      waitDrain("rotate", 100);

      @(negedge clk);
      iSwitch = 1'b1;
      pushClear(1'b0, 1024);
      repeat (4) @(negedge clk);
      chk("fill_rotate", 48'(oFillCnt), {12'd0, 9'd4, 9'd4, 9'd4, 9'd4});
      waitDrain("clear_b0", 1100);

      // Channel 2 alone, three words.
      @(negedge clk);
      srcQ[2].push_back(12'h123);
      srcQ[2].push_back(12'h456);
      srcQ[2].push_back(12'h789);
      expQ.push_back(mkWr(1'b0, 10'd512, 12'h123, 1'b0));
      expQ.push_back(mkWr(1'b0, 10'd513, 12'h456, 1'b0));
      expQ.push_back(mkWr(1'b0, 10'd514, 12'h789, 1'b0));
      waitDrain("ch2_words", 100);

      @(negedge clk);
      iSwitch = 1'b0;
      pushClear(1'b1, 1024);
      repeat (4) @(negedge clk);
      chk("fill_ch2", 48'(oFillCnt), {12'd0, 9'd0, 9'd3, 9'd0, 9'd0});
      waitDrain("clear_b1", 1100);

      // Channel 0 overruns its region: two words discarded, overflow flagged.
      @(negedge clk);
      chk("ovf_before", 48'(oOvf), 48'd0);
      for (int i = 0; i < 258; i++) begin
         w = 12'(i) ^ 12'h3C3;
         srcQ[0].push_back(w);
         if (i < 256) expQ.push_back(mkWr(1'b1, 10'(i), w, 1'b0));
      end
      n = 0;
      while ((srcQ[0].size() > 0 || expQ.size() > 0) && n < 800) begin
         @(negedge clk);
         n++;
      end
      chk("ovf_src_drained", 48'(srcQ[0].size()), 48'd0);
      chk("ovf_writes", 48'(expQ.size()), 48'd0);
      repeat (4) @(negedge clk);
      chk("ovf_set", 48'(oOvf), 48'h1);

      // Toggle, then interrupt that clear once address 500 has been written.
      iSwitch = 1'b1;
      pushClear(1'b0, 501);
      repeat (4) @(negedge clk);
      chk("fill_ovf", 48'(oFillCnt), 48'd256);
      chk("ovf_kept", 48'(oOvf), 48'h1);
      waitDrain("clear_partial", 600);
      iSwitch = 1'b0;
      pushClear(1'b1, 1024);
      waitDrain("clear_restart", 1100);
      repeat (2) @(negedge clk);
      chk("fill_after_restart", 48'(oFillCnt), 48'd0);
      chk("ready_after_restart", 48'(oReady), 48'hF);

      iClrOvf = 1'b1;
      @(negedge clk);
      iClrOvf = 1'b0;
      @(negedge clk);
      chk("ovf_clear", 48'(oOvf), 48'd0);

      // Toggle lands in the cycle channel 1's word is granted: word dropped.
      srcQ[1].push_back(12'h5A5);
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (oReady[1] !== 1'b0 && n < 20);
      chk("ch1_held", 48'(oReady[1]), 48'd0);
      iSwitch = 1'b1;
      pushClear(1'b0, 1024);
      waitDrain("clear_drop", 1100);
      repeat (4) @(negedge clk);
      chk("ch1_consumed", 48'(srcQ[1].size()), 48'd0);

      iSwitch = 1'b0;
      pushClear(1'b1, 1024);
      repeat (4) @(negedge clk);
      chk("fill_drop", 48'(oFillCnt), 48'd0);
      waitDrain("clear_final", 1100);
      repeat (5) @(negedge clk);
      chk("final_wren", 48'(oWrEn), 48'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
